// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rf_arb_pkg
// Brief   : Shared types and default sizing for the register-file write
//           arbiter (photon FIFO entry, issue-source select).
// Rev     : 1.0  initial release
// ============================================================================
package rf_arb_pkg;

   localparam int DEF_DEPTH = 4;
   localparam int DEF_AW    = 5;
   localparam int DEF_DW    = 32;

   // One queued photon write at default widths; live=0 means the entry
   // still occupies a slot but must never reach the register file.
   typedef struct packed {
      logic [DEF_AW-1:0] addr;
      logic [DEF_DW-1:0] data;
      logic              live;
   } ph_entry_t;

   // Which source owns the write port in the next cycle.
   typedef enum logic [1:0] {
      SRC_NONE   = 2'd0,
      SRC_CORE   = 2'd1,
      SRC_PHOTON = 2'd2
   } wr_src_e;

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : rf_write_arbiter_if
// Brief   : Bundle of core writeback, photon request and register-file write
//           signals around the write arbiter. master = surroundings,
//           slave = arbiter.
// Rev     : 1.0  initial release
// ============================================================================
interface rf_write_arbiter_if
   import rf_arb_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW
);
   logic                   core_we;
   logic [AW-1:0]          core_rd;
   logic [DW-1:0]          core_data;
   logic                   ph_valid;
   logic [AW-1:0]          ph_addr;
   logic [DW-1:0]          ph_data;
   logic                   ph_ready;
   logic                   rf_we;
   logic [AW-1:0]          rf_addr;
   logic [DW-1:0]          rf_data;
   logic                   ph_pending;
   logic [$clog2(DEPTH):0] ph_count;

   modport master (
      output core_we, core_rd, core_data, ph_valid, ph_addr, ph_data,
      input  ph_ready, rf_we, rf_addr, rf_data, ph_pending, ph_count
   );

   modport slave (
      input  core_we, core_rd, core_data, ph_valid, ph_addr, ph_data,
      output ph_ready, rf_we, rf_addr, rf_data, ph_pending, ph_count
   );
endinterface
`default_nettype wire

// File: rtl/rf_arb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : rf_arb_fifo
// Brief   : Photon write queue. Circular buffer with per-entry valid/live
//           bits; a core write to register X kills every queued entry for X
//           (and a same-cycle push to X) so the core value stays final.
//           Killed entries keep their slot until drained.
//           Macro RF_WRITE_ARB_STATS_EN adds a per-cycle killed-entry count.
// Rev     : 1.0  initial release
// ============================================================================
module rf_arb_fifo #(
   parameter  int DEPTH = 4,
   parameter  int AW    = 5,
   parameter  int DW    = 32,
   localparam int PW    = $clog2(DEPTH)
) (
   input  wire           clk,
   input  wire           Rst,
   input  wire           i_push,
   input  wire  [AW-1:0] i_push_addr,
   input  wire  [DW-1:0] i_push_data,
   input  wire           i_pop,
   input  wire           i_kill_en,
   input  wire  [AW-1:0] i_kill_addr,
   output logic [AW-1:0] o_head_addr,
   output logic [DW-1:0] o_head_data,
   output logic          o_head_live,
   output logic [PW:0]   o_count,
   output logic          o_ready,
   output logic          o_pending
`ifdef RF_WRITE_ARB_STATS_EN
   ,
   output logic [PW:0]   o_kill_cnt
`endif
);

   localparam logic [PW:0] c_full = (PW+1)'(DEPTH);

   logic [AW-1:0]    r_addr [DEPTH];
   logic [DW-1:0]    r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_live;
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [PW:0]      r_count;
   logic [DEPTH-1:0] w_hit;
   logic             w_push_dead;

   // Per-entry address compare against the killing core write.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
         assign w_hit[gi] = i_kill_en & r_valid[gi] & (r_addr[gi] == i_kill_addr);
      end
   endgenerate

   // A push to x0, or to the register the core is writing now, is dead on arrival.
   assign w_push_dead = (i_push_addr == '0) | (i_kill_en & (i_push_addr == i_kill_addr));

   // Payload storage; no reset needed because valid bits gate every use.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_addr[r_tail] <= i_push_addr;
         r_data[r_tail] <= i_push_data;
      end
   end

   // Pointers, occupancy and valid/live flags. Push and pop never target the
   // same slot because pop needs count>0 and push needs count<DEPTH.
   always_ff @(posedge clk) begin
      if (Rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         r_live  <= '0;
      end else begin
         r_live <= r_live & ~w_hit;
         if (i_pop) begin
            r_valid[r_head] <= 1'b0;
            r_live[r_head]  <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         if (i_push) begin
            r_valid[r_tail] <= 1'b1;
            r_live[r_tail]  <= ~w_push_dead;
            r_tail          <= r_tail + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_addr = r_addr[r_head];
   assign o_head_data = r_data[r_head];
   assign o_head_live = r_live[r_head];
   assign o_count     = r_count;
   assign o_ready     = (r_count != c_full);
   assign o_pending   = |(r_valid & r_live);

`ifdef RF_WRITE_ARB_STATS_EN
   // Entries that lose their live bit this cycle, plus a dead-on-arrival push.
   always_comb begin
      o_kill_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_hit[i] & r_live[i]) o_kill_cnt = o_kill_cnt + 1'b1;
      end
      if (i_push & w_push_dead) o_kill_cnt = o_kill_cnt + 1'b1;
   end
`endif

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rf_write_arbiter
// Brief   : Merges core writeback and photon accelerator writes into one
//           registered register-file write port. Core always wins; photon
//           writes queue in rf_arb_fifo and drain in core-idle cycles.
//           Macro RF_WRITE_ARB_STATS_EN adds four 32-bit event counters.
// Rev     : 1.0  initial release
// ============================================================================
module rf_write_arbiter
   import rf_arb_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW
) (
   input  wire                clk,
   input  wire                Rst,
   rf_write_arbiter_if.slave  bus
`ifdef RF_WRITE_ARB_STATS_EN
   ,
   output logic [31:0]        stat_core_writes,
   output logic [31:0]        stat_ph_writes,
   output logic [31:0]        stat_ph_killed,
   output logic [31:0]        stat_full_cycles
`endif
);

   localparam int PW = $clog2(DEPTH);

   logic          w_core_hit;
   logic          w_push;
   logic          w_pop;
   logic [AW-1:0] w_head_addr;
   logic [DW-1:0] w_head_data;
   logic          w_head_live;
   logic [PW:0]   w_count;
   logic          w_ready;
   logic          w_pending;
   wr_src_e       w_src;
   logic          r_rf_we;
   logic [AW-1:0] r_rf_addr;
   logic [DW-1:0] r_rf_data;
`ifdef RF_WRITE_ARB_STATS_EN
   logic [PW:0]   w_kill_cnt;
`endif

   // x0 is hardwired, so a core write to it is no write at all.
   assign w_core_hit = bus.core_we & (|bus.core_rd);
   // Acceptance looks only at registered occupancy, never at a same-cycle pop.
   assign w_push     = bus.ph_valid & w_ready;
   assign w_pop      = ~w_core_hit & (w_count != '0);

   rf_arb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fifo (
      .clk         (clk),
      .Rst         (Rst),
      .i_push      (w_push),
      .i_push_addr (bus.ph_addr),
      .i_push_data (bus.ph_data),
      .i_pop       (w_pop),
      .i_kill_en   (w_core_hit),
      .i_kill_addr (bus.core_rd),
      .o_head_addr (w_head_addr),
      .o_head_data (w_head_data),
      .o_head_live (w_head_live),
      .o_count     (w_count),
      .o_ready     (w_ready),
      .o_pending   (w_pending)
`ifdef RF_WRITE_ARB_STATS_EN
      ,
      .o_kill_cnt  (w_kill_cnt)
`endif
   );

   // Issue select: core first, then a live head; a killed head drains silently.
   always_comb begin
      w_src = SRC_NONE;
      if (w_core_hit)              w_src = SRC_CORE;
      else if (w_pop & w_head_live) w_src = SRC_PHOTON;
   end

   // Output register; address/data hold when nothing issues.
   always_ff @(posedge clk) begin
      if (Rst) begin
         r_rf_we   <= 1'b0;
         r_rf_addr <= '0;
         r_rf_data <= '0;
      end else begin
         case (w_src)
            SRC_CORE: begin
               r_rf_we   <= 1'b1;
               r_rf_addr <= bus.core_rd;
               r_rf_data <= bus.core_data;
            end
            SRC_PHOTON: begin
               r_rf_we   <= 1'b1;
               r_rf_addr <= w_head_addr;
               r_rf_data <= w_head_data;
            end
            default: r_rf_we <= 1'b0;
         endcase
      end
   end

   assign bus.rf_we      = r_rf_we;
   assign bus.rf_addr    = r_rf_addr;
   assign bus.rf_data    = r_rf_data;
   assign bus.ph_ready   = w_ready;
   assign bus.ph_pending = w_pending;
   assign bus.ph_count   = w_count;

`ifdef RF_WRITE_ARB_STATS_EN
   logic [31:0] r_stat_core;
   logic [31:0] r_stat_ph;
   logic [31:0] r_stat_killed;
   logic [31:0] r_stat_full;

   // Free-running event counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (Rst) begin
         r_stat_core   <= '0;
         r_stat_ph     <= '0;
         r_stat_killed <= '0;
         r_stat_full   <= '0;
      end else begin
         if (w_src == SRC_CORE)         r_stat_core <= r_stat_core + 32'd1;
         if (w_src == SRC_PHOTON)       r_stat_ph   <= r_stat_ph + 32'd1;
         if (bus.ph_valid & ~w_ready)   r_stat_full <= r_stat_full + 32'd1;
         r_stat_killed <= r_stat_killed + 32'(w_kill_cnt);
      end
   end

   assign stat_core_writes = r_stat_core;
   assign stat_ph_writes   = r_stat_ph;
   assign stat_ph_killed   = r_stat_killed;
   assign stat_full_cycles = r_stat_full;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rf_write_arbiter
// Brief   : Directed self-checking bench for rf_write_arbiter. Expected
//           register-file writes are queued as stimulus is applied and
//           compared in order whenever rf_we is seen.
// Rev     : 1.0  initial release
// ============================================================================
module tb_rf_write_arbiter;
   import rf_arb_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic clk;
   logic Rst;
   int   nvec;
   int   nerr;
   ph_entry_t exp_q[$];

   rf_write_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

`ifdef RF_WRITE_ARB_STATS_EN
   logic [31:0] stat_core_writes;
   logic [31:0] stat_ph_writes;
   logic [31:0] stat_ph_killed;
   logic [31:0] stat_full_cycles;
`endif

   rf_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk              (clk),
      .Rst              (Rst),
      .bus              (bus)
`ifdef RF_WRITE_ARB_STATS_EN
      ,
      .stat_core_writes (stat_core_writes),
      .stat_ph_writes   (stat_ph_writes),
      .stat_ph_killed   (stat_ph_killed),
      .stat_full_cycles (stat_full_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ph_entry_t e;
      e.addr = a;
      e.data = d;
      e.live = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic cwe, input logic [AW-1:0] crd, input logic [DW-1:0] cd,
                        input logic pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd);
      bus.core_we   = cwe;
      bus.core_rd   = crd;
      bus.core_data = cd;
      bus.ph_valid  = pv;
      bus.ph_addr   = pa;
      bus.ph_data   = pd;
   endtask

   // One clock, then scoreboard any register-file write the edge produced.
   task automatic step();
      ph_entry_t e;
      @(posedge clk);
      #1;
      if (bus.rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_we", {63'd0, bus.rf_we}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {59'd0, bus.rf_addr}, {59'd0, e.addr});
            chk("wr_data", {32'd0, bus.rf_data}, {32'd0, e.data});
         end
      end
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      Rst  = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      step();
      step();
      chk("rst_we",      {63'd0, bus.rf_we}, 64'd0);
      chk("rst_addr",    {59'd0, bus.rf_addr}, 64'd0);
      chk("rst_data",    {32'd0, bus.rf_data}, 64'd0);
      chk("rst_ready",   {63'd0, bus.ph_ready}, 64'd1);
      chk("rst_pending", {63'd0, bus.ph_pending}, 64'd0);
      chk("rst_count",   {61'd0, bus.ph_count}, 64'd0);
      Rst = 1'b0;

      // Core-only writes; x0 is ignored.
      drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
      expect_wr(5, 32'hDEADBEEF);
      step();
      chk("core_we", {63'd0, bus.rf_we}, 64'd1);
      drive(1, 0, 32'h123, 0, 0, 0);
      step();
      chk("core_x0_we", {63'd0, bus.rf_we}, 64'd0);
      chk("core_x0_hold", {59'd0, bus.rf_addr}, 64'd5);

      // Photon drain in order on consecutive cycles.
      drive(0, 0, 0, 1, 7, 32'h11);
      expect_wr(7, 32'h11);
      step();
      chk("drain_count1", {61'd0, bus.ph_count}, 64'd1);
      chk("drain_pend1",  {63'd0, bus.ph_pending}, 64'd1);
      drive(0, 0, 0, 1, 8, 32'h22);
      expect_wr(8, 32'h22);
      step();
      chk("drain_we1", {63'd0, bus.rf_we}, 64'd1);
      drive(0, 0, 0, 0, 0, 0);
      step();
      chk("drain_we2",    {63'd0, bus.rf_we}, 64'd1);
      chk("drain_count0", {61'd0, bus.ph_count}, 64'd0);
      chk("drain_pend0",  {63'd0, bus.ph_pending}, 64'd0);
      step();
      chk("drain_idle_we", {63'd0, bus.rf_we}, 64'd0);

      // Priority: core holds the port for three cycles.
      drive(1, 9, 32'h900, 1, 3, 32'hAA);
      expect_wr(9, 32'h900);
      step();
      drive(1, 9, 32'h901, 0, 0, 0);
      expect_wr(9, 32'h901);
      step();
      drive(1, 9, 32'h902, 0, 0, 0);
      expect_wr(9, 32'h902);
      step();
      chk("prio_count", {61'd0, bus.ph_count}, 64'd1);
      drive(0, 0, 0, 0, 0, 0);
      expect_wr(3, 32'hAA);
      step();
      chk("prio_ph_we", {63'd0, bus.rf_we}, 64'd1);
      chk("prio_count0", {61'd0, bus.ph_count}, 64'd0);

      // Kill of a queued entry by a later core write.
      drive(1, 10, 32'hA0, 1, 4, 32'h55);
      expect_wr(10, 32'hA0);
      step();
      drive(1, 4, 32'h99, 0, 0, 0);
      expect_wr(4, 32'h99);
      step();
      chk("kill_count", {61'd0, bus.ph_count}, 64'd1);
      chk("kill_pend",  {63'd0, bus.ph_pending}, 64'd0);
      drive(0, 0, 0, 0, 0, 0);
      step();
      chk("kill_pop_we", {63'd0, bus.rf_we}, 64'd0);
      chk("kill_count0", {61'd0, bus.ph_count}, 64'd0);

      // Same-cycle push and core write to the same register.
      drive(1, 4, 32'h98, 1, 4, 32'h77);
      expect_wr(4, 32'h98);
      step();
      chk("same_count", {61'd0, bus.ph_count}, 64'd1);
      chk("same_pend",  {63'd0, bus.ph_pending}, 64'd0);
      drive(0, 0, 0, 0, 0, 0);
      step();
      chk("same_pop_we", {63'd0, bus.rf_we}, 64'd0);

      // Push to x0 is accepted but never written.
      drive(0, 0, 0, 1, 0, 32'h1);
      step();
      chk("x0_count", {61'd0, bus.ph_count}, 64'd1);
      chk("x0_pend",  {63'd0, bus.ph_pending}, 64'd0);
      drive(0, 0, 0, 0, 0, 0);
      step();
      chk("x0_pop_we", {63'd0, bus.rf_we}, 64'd0);
      chk("x0_count0", {61'd0, bus.ph_count}, 64'd0);

      // Fill to DEPTH with the core busy; a fifth request is refused.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 12, 32'hC00 + i, 1, AW'(20 + i), 32'h200 + i);
         expect_wr(12, 32'hC00 + i);
         step();
      end
      chk("full_count", {61'd0, bus.ph_count}, 64'd4);
      chk("full_ready", {63'd0, bus.ph_ready}, 64'd0);
      drive(1, 12, 32'hC10, 1, 30, 32'hBAD);
      expect_wr(12, 32'hC10);
      step();
      chk("full_refuse_count", {61'd0, bus.ph_count}, 64'd4);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) expect_wr(AW'(20 + i), 32'h200 + i);
      for (int i = 0; i < DEPTH; i++) step();
      chk("full_drained", {61'd0, bus.ph_count}, 64'd0);

      // Six more pushes across the pointer wrap with two busy core cycles.
      for (int i = 0; i < 6; i++) begin
         if (i < 2) begin
            drive(1, 14, 32'hE00 + i, 1, AW'(16 + i), 32'h600 + i);
            expect_wr(14, 32'hE00 + i);
         end else begin
            drive(0, 0, 0, 1, AW'(16 + i), 32'h600 + i);
            expect_wr(AW'(16 + i - 2), 32'h600 + i - 2);
         end
         step();
      end
      chk("wrap_count", {61'd0, bus.ph_count}, 64'd2);
      drive(0, 0, 0, 0, 0, 0);
      expect_wr(20, 32'h604);
      expect_wr(21, 32'h605);
      step();
      step();
      chk("wrap_count0", {61'd0, bus.ph_count}, 64'd0);

      // Reset with three live entries queued.
      for (int i = 0; i < 3; i++) begin
         drive(1, 13, 32'hD00 + i, 1, AW'(24 + i), 32'h700 + i);
         expect_wr(13, 32'hD00 + i);
         step();
      end
      chk("pre_rst_count", {61'd0, bus.ph_count}, 64'd3);
      drive(0, 0, 0, 0, 0, 0);
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      chk("mrst_we",      {63'd0, bus.rf_we}, 64'd0);
      chk("mrst_count",   {61'd0, bus.ph_count}, 64'd0);
      chk("mrst_pending", {63'd0, bus.ph_pending}, 64'd0);
      chk("mrst_ready",   {63'd0, bus.ph_ready}, 64'd1);
      for (int i = 0; i < 5; i++) step();
      chk("post_rst_we", {63'd0, bus.rf_we}, 64'd0);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Merges the two register-file write sources into one registered write port: core writeback (MEM_WB stage) and photon accelerator register writes.
- Core writeback always has priority and never stalls.
- Photon writes are buffered in a small FIFO and drained in cycles with no core write.
- Sits directly upstream of the register file's write port.

Parameters:
- DEPTH, 4, photon write FIFO entries (power of 2, ≥2)
- AW, 5, register address width
- DW, 32, register data width

Ports:
- clk  in  1  system clock
- Rst  in  1  synchronous active-high reset
- core_we  in  1  MEM_WB_regwrite
- core_rd  in  AW  MEM_WB_rd
- core_data  in  DW  WB_res
- ph_valid  in  1  photon write request
- ph_addr  in  AW  photon target register
- ph_data  in  DW  photon write data
- ph_ready  out  1  FIFO can accept (count < DEPTH)
- rf_we  out  1  register-file write enable (registered)
- rf_addr  out  AW  register-file write address (registered)
- rf_data  out  DW  register-file write data (registered)
- ph_pending  out  1  FIFO holds ≥1 live entry
- ph_count  out  $clog2(DEPTH)+1  FIFO occupancy, live and killed entries

Behaviour:
- Clock and reset: one clock clk; reset Rst is synchronous and active-high.
- Reset values:
  - rf_we=0, rf_addr=0, rf_data=0.
  - FIFO empty: head=tail=0, count=0, all entry valid bits 0.
  - ph_ready=1, ph_pending=0.
- Photon accept:
  - Handshake ph_valid & ph_ready pushes {addr, data, live=1} at tail.
  - ph_ready depends only on registered count, not on a same-cycle pop. A full FIFO never accepts, even while popping.
  - A push with ph_addr==0 is accepted but stored with live=0.
- Core write:
  - core_we & |core_rd drives the next cycle rf_we=1, rf_addr=core_rd, rf_data=core_data.
  - Latency is 1 cycle.
  - core_rd==0 is ignored and treated as no core write.
- Drain:
  - In a cycle with no qualifying core write and count>0, pop head.
  - If head is live: next cycle rf_we=1 with head addr/data.
  - If head is killed: pop silently with rf_we=0. A killed entry occupies one drain slot.
  - At most one pop per cycle.
- Idle: otherwise rf_we=0 next cycle; rf_addr/rf_data hold their previous values.
- Ordering and kill rule:
  - A qualifying core write to register X clears the live bit of every FIFO entry whose addr==X, in the same cycle.
  - A photon push in the same cycle with ph_addr==X is stored killed.
  - Result: the core value is always final for X.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Wrap-around: pointers are log2(DEPTH) bits and wrap modulo DEPTH. count disambiguates full from empty.
- ph_pending: OR of valid&live across occupied entries (combinational from registers).
- Reset mid-operation: Rst discards all FIFO contents, including live entries, and forces rf_we=0 next cycle. No partial drain.

Optional Feature:
- Macro RF_WRITE_ARB_STATS_EN.
- Defined: adds outputs stat_core_writes, stat_ph_writes, stat_ph_killed and stat_full_cycles.
  - Each is 32 bits, cleared by Rst, and wraps at 2^32.
  - They count, respectively: core writes issued, photon writes issued, entries killed (at kill time or via x0 push), and cycles with ph_valid & !ph_ready.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package rf_arb_pkg holds:
  - typedef ph_entry_t {logic [AW-1:0] addr; logic [DW-1:0] data; logic live;}
  - the default DEPTH/AW/DW constants
  - typedef wr_src_e {SRC_NONE, SRC_CORE, SRC_PHOTON}, used for issue-select muxing.
- One sub-module is natural: rf_arb_fifo, the storage array with per-entry address compare and kill, pointers and count. The top holds priority select and the output register.

Test Plan:
- Core only: core_we=1, core_rd=5, core_data=0xDEADBEEF → next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF. core_rd=0 → rf_we=0.
- Photon drain:
  - Push (7, 0x11) and then (8, 0x22) with core idle → rf writes 7/0x11 then 8/0x22 on consecutive cycles.
  - ph_count returns to 0; ph_pending falls.
- Priority:
  - Push (3, 0xAA) while core writes reg 9 for 3 cycles → core writes appear 3 cycles in a row.
  - Photon write 3/0xAA issues in the 4th cycle.
- Kill:
  - Queue (4, 0x55); core writes reg 4 = 0x99 before the drain → rf gets 4/0x99 only.
  - The killed entry pops with rf_we=0.
  - A same-cycle push to 4 with core write to 4 is likewise dropped.
- Full/wrap:
  - Push DEPTH entries with core busy → ph_ready=0 at count=4. A 5th ph_valid is not accepted.
  - Release the core → 4 writes drain in order. Push 6 more to exercise pointer wrap; order is preserved.
- Reset mid-operation: 3 entries queued, assert Rst for 1 cycle → count=0, ph_pending=0, rf_we=0; no stale photon write ever issues.
